// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-side bundle for fifo_wr_arbiter.
// master = arbiter side, slave = requesters + FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      full;
  logic [3:0]                fifo_counter;
  logic                      wr_en;
  logic [DATA_W-1:0]         wdata;
  logic                      busy;
  logic [IDX_W-1:0]          owner;
  logic [15:0]               stall_cnt;

  modport master (
    input  req, req_data, full, fifo_counter,
    output gnt, wr_en, wdata, busy, owner, stall_cnt
  );

  modport slave (
    output req, req_data, full, fifo_counter,
    input  gnt, wr_en, wdata, busy, owner, stall_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port; one beat per cycle,
// up to BURST_MAX beats per tenure, with almost-full backpressure.
module fifo_wr_arbiter_lane #(
  parameter int          IDX_W = 2,
  parameter int unsigned IDX   = 0
) (
  input  logic             req,
  input  logic             in_burst,
  input  logic             room,
  input  logic [IDX_W-1:0] owner,
  output logic             gnt
);
  assign gnt = in_burst & room & req & (owner == IDX_W'(IDX));
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4,
  parameter int AFULL_LVL = 14
) (
  input  logic              wr_clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [BEAT_W-1:0]  beat_cnt;
  logic               wr_en;
  logic [DATA_W-1:0]  wdata;
  logic               busy;
  logic [15:0]        stall_cnt;

  logic [NUM_REQ-1:0] gnt;
  logic               room;
  logic               own_req;
  logic               ok;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   nxt_ptr;

  // Almost-full threshold leaves one slot for the beat already in the wr_en stage.
  assign room    = !bus.full && (int'(bus.fifo_counter) < AFULL_LVL);
  assign own_req = bus.req[owner];
  assign ok      = |gnt;
  assign nxt_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.IDX_W(IDX_W), .IDX(i)) u_lane (
      .req      (bus.req[i]),
      .in_burst (state == BURST),
      .room     (room),
      .owner    (owner),
      .gnt      (gnt[i])
    );
  end

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx  = 0;
    pick = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (bus.req[idx]) pick = IDX_W'(idx);
    end
  end

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      wr_en     <= 1'b0;
      wdata     <= '0;
      busy      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      wr_en <= ok;
      if (ok) wdata <= bus.req_data[int'(owner)*DATA_W +: DATA_W];
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= BURST;
            busy     <= 1'b1;
            owner    <= pick;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (!own_req) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= nxt_ptr;
          end else if (ok) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (beat_cnt == BEAT_W'(BURST_MAX - 1)) begin
              state  <= IDLE;
              busy   <= 1'b0;
              rr_ptr <= nxt_ptr;
            end
          end else if (stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.wr_en     = wr_en;
  assign bus.wdata     = wdata;
  assign bus.busy      = busy;
  assign bus.owner     = owner;
  assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized + directed bench for fifo_wr_arbiter against a cycle-level
// transaction model (tenures, beat counts, round-robin pointer arithmetic).
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int AF = 14;

  logic wr_clk = 1'b0;
  logic rst    = 1'b0;
  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(BM), .AFULL_LVL(AF)) dut (
    .wr_clk (wr_clk),
    .rst    (rst),
    .bus    (bus.master)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus state
  logic [N-1:0]  s_req;
  logic [DW-1:0] s_data [N];
  logic          s_full;
  logic [3:0]    s_cnt;
  bit            rnd;

  // reference model state
  bit            m_busy;
  int            m_own, m_beats, m_rr, m_stall;
  bit            m_wr;
  logic [DW-1:0] m_wdata;
  logic [N-1:0]  last_gnt;

  logic [DW-1:0] wlog [$];
  int            glog [$];
  int            gstep [$];
  int            cyc = 0;
  int            st0;

  task automatic m_reset();
    m_busy = 0; m_own = 0; m_beats = 0; m_rr = 0; m_stall = 0;
    m_wr = 0; m_wdata = '0; last_gnt = '0;
  endtask

  task automatic drive();
    bus.req = s_req;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = s_data[i];
    bus.full = s_full;
    bus.fifo_counter = s_cnt;
  endtask

  task automatic step();
    logic [N-1:0] exp_g;
    bit nwr;
    bit found;
    @(negedge wr_clk);
    cyc++;
    chk("wr_en", 32'(bus.wr_en), 32'(m_wr));
    chk("wdata", 32'(bus.wdata), 32'(m_wdata));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("owner", 32'(bus.owner), 32'(m_own));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    if (bus.wr_en) wlog.push_back(bus.wdata);
    drive();
    #1;
    exp_g = '0;
    nwr   = 0;
    found = 0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!found && s_req[(m_rr + k) % N]) begin
          m_own = (m_rr + k) % N;
          found = 1;
        end
      end
      if (found) begin
        m_busy  = 1;
        m_beats = 0;
      end
    end else if (!s_req[m_own]) begin
      m_busy = 0;
      m_rr   = (m_own + 1) % N;
    end else if (s_full || int'(s_cnt) >= AF) begin
      if (m_stall < 65535) m_stall++;
    end else begin
      exp_g[m_own] = 1'b1;
      nwr     = 1;
      m_wdata = s_data[m_own];
      m_beats++;
      if (m_beats == BM) begin
        m_busy = 0;
        m_rr   = (m_own + 1) % N;
      end
      s_data[m_own] = rnd ? DW'($urandom) : s_data[m_own] + 8'd1;
    end
    m_wr = nwr;
    chk("gnt", 32'(bus.gnt), 32'(exp_g));
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i]) begin
        glog.push_back(i);
        gstep.push_back(cyc);
      end
    end
    last_gnt = exp_g;
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    s_req = '0; s_full = 0; s_cnt = '0;
    drive();
    rst = 1'b0;
    m_reset();
    @(negedge wr_clk);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    @(negedge wr_clk);
    rst = 1'b1;
    wlog.delete(); glog.delete(); gstep.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rnd = 0;
    for (int i = 0; i < N; i++) s_data[i] = '0;
    s_req = '0; s_full = 0; s_cnt = '0;
    drive();
    do_reset();

    // single requester, 6 beats: burst of 4, one idle cycle, then 2
    s_data[0] = 8'hA0;
    s_req = 4'b0001;
    for (int t = 0; t < 40 && gstep.size() < 6; t++) step();
    s_req = '0;
    repeat (3) step();
    chk("single_nbeats", 32'(gstep.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("single_data", (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF, 32'hA0 + 32'(i));
    if (gstep.size() == 6) begin
      chk("single_burst1_span", 32'(gstep[3] - gstep[0]), 32'd3);
      chk("single_idle_gap", 32'(gstep[4] - gstep[3]), 32'd2);
      chk("single_burst2_span", 32'(gstep[5] - gstep[4]), 32'd1);
    end

    // round robin with everyone requesting: 0,1,2,3,0 with 4 beats each
    do_reset();
    for (int i = 0; i < N; i++) s_data[i] = DW'(i * 16);
    s_req = 4'b1111;
    for (int t = 0; t < 60 && glog.size() < 20; t++) step();
    s_req = '0;
    step();
    chk("rr_ngrants", 32'(glog.size()), 32'd20);
    for (int k = 0; k < 20; k++)
      chk("rr_owner_seq", (k < glog.size()) ? 32'(glog[k]) : 32'hFFFF_FFFF, 32'((k / 4) % 4));

    // backpressure: almost-full for 3 cycles mid-burst
    do_reset();
    s_data[0] = 8'h10;
    s_req = 4'b0001;
    for (int t = 0; t < 20 && glog.size() < 2; t++) step();
    st0 = int'(bus.stall_cnt);
    s_cnt = 4'd14;
    repeat (3) step();
    chk("bp_no_grant", 32'(glog.size()), 32'd2);
    s_cnt = 4'd0;
    for (int t = 0; t < 20 && glog.size() < 4; t++) step();
    s_req = '0;
    repeat (2) step();
    chk("bp_stall_delta", 32'(int'(bus.stall_cnt) - st0), 32'd3);
    chk("bp_nwrites", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("bp_data", (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF, 32'h10 + 32'(i));

    // early release after 2 beats: next tenure skips idle index 1, goes to 2
    do_reset();
    s_data[0] = 8'h30;
    s_data[2] = 8'h50;
    s_req = 4'b0101;
    for (int t = 0; t < 20 && glog.size() < 2; t++) step();
    s_req[0] = 1'b0;
    for (int t = 0; t < 10 && glog.size() < 3; t++) step();
    chk("early_next_owner", (glog.size() >= 3) ? 32'(glog[2]) : 32'hFFFF_FFFF, 32'd2);
    s_req = '0;
    repeat (2) step();

    // randomized traffic
    do_reset();
    rnd = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_gnt[i]) s_req[i] = ($urandom_range(0, 3) != 0);
        else if (s_req[i]) begin
          if ($urandom_range(0, 31) == 0) s_req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          s_req[i]  = 1'b1;
          s_data[i] = DW'($urandom);
        end
      end
      s_full = ($urandom_range(0, 7) == 0);
      s_cnt  = 4'($urandom_range(0, 15));
      step();
    end

    // reset asserted while wr_en is high
    rnd = 0;
    s_full = 0; s_cnt = '0; s_req = 4'b1111;
    for (int t = 0; t < 20 && !m_wr; t++) step();
    @(posedge wr_clk);
    #2;
    chk("midrst_pre_wr_en", 32'(bus.wr_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("midrst_wdata", 32'(bus.wdata), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_owner", 32'(bus.owner), 32'd0);
    chk("midrst_stall", 32'(bus.stall_cnt), 32'd0);
    chk("midrst_gnt", 32'(bus.gnt), 32'd0);
    m_reset();
    @(negedge wr_clk);
    bus.req = '0;
    rst = 1'b1;
    glog.delete();
    step();
    @(posedge wr_clk);
    #1;
    chk("midrst_first_owner", 32'(bus.owner), 32'd0);
    for (int t = 0; t < 10 && glog.size() < 1; t++) step();
    chk("midrst_first_grant", (glog.size() >= 1) ? 32'(glog[0]) : 32'hFFFF_FFFF, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters.
REQ-002 SHALL have parameter DATA_W, default 8, FIFO write-data width.
REQ-003 SHALL have parameter BURST_MAX, default 4, maximum beats per grant tenure.
REQ-004 SHALL have parameter AFULL_LVL, default 14, fifo_counter level at or above which no new beat is accepted.
REQ-005 SHALL have port wr_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester write request, level, held until granted.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port gnt  output  NUM_REQ  one-hot beat-accept strobe; high in the cycle the beat is taken.
REQ-010 SHALL have port full  input  1  FIFO full flag, write-clock domain.
REQ-011 SHALL have port fifo_counter  input  4  FIFO occupancy, write-clock domain.
REQ-012 SHALL have port wr_en  output  1  registered FIFO write enable.
REQ-013 SHALL have port wdata  output  DATA_W  registered FIFO write data.
REQ-014 SHALL have port busy  output  1  high while state is BURST.
REQ-015 SHALL have port owner  output  2  index of the current or last burst owner.
REQ-016 SHALL have port stall_cnt  output  16  saturating count of BURST cycles with req[owner] high and beat refused.

Function
REQ-017 SHALL implement states IDLE and BURST.
REQ-018 IDLE: if any req high, SHALL select the first requester high in round-robin order starting at rr_ptr, load owner, clear beat_cnt, go BURST; no gnt in IDLE.
REQ-019 ok SHALL be defined as: state BURST, req[owner]=1, full=0, and fifo_counter < AFULL_LVL.
REQ-020 gnt[owner] SHALL be combinational and equal to ok; all other gnt bits 0.
REQ-021 On an ok cycle, the next edge SHALL set wr_en=1 and wdata=req_data[owner], a 1-cycle latency from gnt to write.
REQ-022 On a non-ok cycle, the next edge SHALL set wr_en=0; wdata SHALL hold its last value.
REQ-023 On an ok cycle, beat_cnt SHALL increment; when the accepted beat is beat BURST_MAX, the FSM SHALL go IDLE.
REQ-024 In BURST, if req[owner]=0, the FSM SHALL go IDLE with no gnt that cycle.
REQ-025 On every BURST->IDLE transition, rr_ptr SHALL be set to (owner+1) mod NUM_REQ.
REQ-026 Backpressure in BURST (full=1 or counter >= AFULL_LVL while req[owner]=1) SHALL keep state BURST, hold beat_cnt, and increment stall_cnt, saturating at 0xFFFF.
REQ-027 Requests from non-owners during BURST SHALL be ignored until the FSM returns to IDLE.
REQ-028 One IDLE arbitration cycle SHALL separate consecutive bursts, including bursts by the same requester.
REQ-029 AFULL_LVL SHALL absorb the 1-cycle wr_en latency, so an accepted beat is never written into a full FIFO.

Reset
REQ-030 While rst=0: state IDLE, rr_ptr=0, owner=0, beat_cnt=0, wr_en=0, wdata=0, gnt=0, busy=0, stall_cnt=0.
REQ-031 Reset asserted mid-burst SHALL drop wr_en asynchronously; the in-flight beat is discarded.
REQ-032 The first arbitration after reset release SHALL give requester 0 highest priority.

Verification
REQ-033 Single requester: req=0001, data 0xA0..0xA5 held per gnt, FIFO empty -> beats A0-A3 in burst 1, one IDLE cycle, then A4-A5; wr_en trails gnt by 1 cycle.
REQ-034 Round-robin: req=1111 continuously -> owner sequence 0,1,2,3,0; each tenure is exactly 4 beats.
REQ-035 Backpressure: fifo_counter=14 for 3 cycles mid-burst -> no gnt, wr_en=0 for those cycles, stall_cnt increases by 3, burst resumes without losing or duplicating data.
REQ-036 Early release: owner drops req after 2 beats -> IDLE next cycle, rr_ptr=owner+1, next burst goes to the next requesting index.
REQ-037 Reset mid-burst: rst low while wr_en=1 -> wr_en=0 immediately, all outputs at reset values, first post-reset grant goes to requester 0 when req=1111.
